// File: rtl/mux_scan_pkg.sv
// Shared types and sizing for the 4:1 mux scan controller.
package mux_scan_pkg;

    localparam int N_CH  = 4;
    localparam int SEL_W = 2;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    // A single-cycle dwell still needs a 1-bit counter.
    function automatic int cnt_width(input int dwell);
        return (dwell > 1) ? $clog2(dwell) : 1;
    endfunction

endpackage

// File: rtl/dwell_timer.sv
// Dwell counter 0..DWELL-1; tick is high on the last count and the count restarts.
// Zero latency from en; held at 0 whenever en is low.
module dwell_timer
    import mux_scan_pkg::*;
#(
    parameter int DWELL = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);

    localparam int CW = cnt_width(DWELL);
    localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

    logic [CW-1:0] cnt;

    assign tick = en && (cnt == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (!en || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/mux_scan_ctrl.sv
// Steps mux sel through channels 0..3 (DWELL cycles each) and packs the y samples into a frame valid 4*DWELL cycles after start.
// frame_valid/frame_ready handshake; a frame completing while one is still held is dropped and sets sticky overrun.
module mux_scan_ctrl
    import mux_scan_pkg::*;
#(
    parameter int DWELL = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             cont,
    input  logic             stop,
    input  logic             y,
    output logic [SEL_W-1:0] sel,
    output logic [N_CH-1:0]  frame,
    output logic             frame_valid,
    input  logic             frame_ready,
    output logic             busy,
    output logic             overrun,
    input  logic             clr_ovr
);

    state_t          state;
    logic            cont_q;
    logic            stop_q;
    logic [N_CH-2:0] samp;
    logic            tick;
    logic            last_ch;
    logic            scan_en;

    assign scan_en = (state == SCAN);
    assign last_ch = (sel == SEL_W'(N_CH - 1));

    dwell_timer #(
        .DWELL (DWELL)
    ) u_dwell_timer (
        .clk  (clk),
        .rst  (rst),
        .en   (scan_en),
        .tick (tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cont_q      <= 1'b0;
            stop_q      <= 1'b0;
            samp        <= '0;
            sel         <= '0;
            frame       <= '0;
            frame_valid <= 1'b0;
            busy        <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            if (frame_valid && frame_ready) begin
                frame_valid <= 1'b0;
            end
            if (clr_ovr) begin
                overrun <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        state  <= SCAN;
                        busy   <= 1'b1;
                        cont_q <= cont;
                        sel    <= '0;
                    end
                end
                SCAN: begin
                    if (stop) begin
                        stop_q <= 1'b1;
                    end
                    if (tick) begin
                        sel <= sel + SEL_W'(1);
                        if (!last_ch) begin
                            samp[sel] <= y;
                        end else begin
                            // Channel 3 is bypassed straight into the frame so it lands on this edge.
                            if (!frame_valid || frame_ready) begin
                                frame       <= {y, samp};
                                frame_valid <= 1'b1;
                            end else begin
                                overrun <= 1'b1;
                            end
                            if (!cont_q || stop_q || stop) begin
                                state  <= IDLE;
                                busy   <= 1'b0;
                                sel    <= '0;
                                stop_q <= 1'b0;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
